rv32e_mem_arbiter: RTL and testbench

Shares one single-port synchronous memory between the RV32E core's instruction-fetch requester and its data load/store requester. This enables a unified program/data RAM. Each requester uses a level req / one-cycle ack handshake. The arbiter sequences every access through a fixed FSM and absorbs a parameterised memory read latency. It sits between rv32e_cpu's fetch/data sides and the RAM.

---
 rtl/rv32e_mem_arbiter_if.sv | 36 +++
 rtl/rv32e_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_rv32e_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32e_mem_arbiter_if.sv
// Bus bundle between the RV32E fetch/data requesters, the arbiter and the shared RAM.
// slave = arbiter side, master = requester/memory side.
interface rv32e_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
   logic              grant_d;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
             busy, grant_d
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
             busy, grant_d
   );
endinterface

// File: rtl/rv32e_mem_arbiter.sv
// Fetch/data arbiter in front of one single-port synchronous RAM (IDLE->ISSUE->[WAIT]->DONE).
// Optional macro RV32E_ARB_ROUND_ROBIN_EN: round-robin on contention instead of data-first.
module rv32e_mem_arbiter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned MEM_LATENCY = 1
) (
   input logic                clk,
   input logic                reset,
   rv32e_mem_arbiter_if.slave bus
);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic              busy_q, busy_d;
   logic              pick_c;

`ifdef RV32E_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On contention grant whichever port did not own the previous grant.
   assign pick_c = (bus.if_req && bus.d_req) ? ~last_q : bus.d_req;

   always_ff @(posedge clk) begin
      if (reset) last_q <= 1'b1;
      else       last_q <= last_d;
   end
`else
   assign pick_c = bus.d_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
         if_ack_q   <= 1'b0;
         d_ack_q    <= 1'b0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
         if_ack_q   <= if_ack_d;
         d_ack_q    <= d_ack_d;
         mem_en_q   <= mem_en_d;
         mem_we_q   <= mem_we_d;
         busy_q     <= busy_d;
      end
   end

   // Outputs are registered, so each *_d reflects the value wanted in the next state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      if_ack_d   = 1'b0;
      d_ack_d    = 1'b0;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
`ifdef RV32E_ARB_ROUND_ROBIN_EN
      last_d     = last_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (bus.if_req || bus.d_req) begin
               owner_d  = pick_c;
               addr_d   = pick_c ? bus.d_addr : bus.if_addr;
               we_d     = pick_c & bus.d_we;
               if (pick_c) wdata_d = bus.d_wdata;
               mem_en_d = 1'b1;
               mem_we_d = pick_c & bus.d_we;
               state_d  = S_ISSUE;
`ifdef RV32E_ARB_ROUND_ROBIN_EN
               last_d   = pick_c;
`endif
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d  = S_DONE;
               d_ack_d  = owner_q;
               if_ack_d = ~owner_q;
            end else begin
               cnt_d   = CNT_W'(MEM_LATENCY);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) begin
               if (owner_q) d_rdata_d  = bus.mem_rdata;
               else         if_rdata_d = bus.mem_rdata;
               d_ack_d  = owner_q;
               if_ack_d = ~owner_q;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = busy_q;
   assign bus.grant_d   = owner_q;
endmodule

// File: tb/tb_rv32e_mem_arbiter.sv
// Directed bench: DUT A (MEM_LATENCY=1) and DUT B (MEM_LATENCY=3), each with its own RAM model.
module tb_rv32e_mem_arbiter;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rv32e_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ba ();
   rv32e_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bb ();

   rv32e_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_a (
      .clk(clk), .reset(rst_a), .bus(ba.slave));
   rv32e_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_b (
      .clk(clk), .reset(rst_b), .bus(bb.slave));

   // RAM models: word-indexed, read data delayed by the configured latency.
   logic [31:0] ram_a [256];
   logic [31:0] ram_b [256];
   logic [31:0] pipe_a;
   logic [31:0] pipe_b [3];
   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = '0;
   logic [31:0] pre_data = '0;

   always @(posedge clk) begin
      if (pre_en) ram_a[pre_idx] <= pre_data;
      else if (ba.mem_en && ba.mem_we) ram_a[ba.mem_addr[9:2]] <= ba.mem_wdata;
      pipe_a <= ba.mem_en ? ram_a[ba.mem_addr[9:2]] : 32'hBAAD_F00D;
   end
   always @(posedge clk) begin
      if (pre_en) ram_b[pre_idx] <= pre_data;
      else if (bb.mem_en && bb.mem_we) ram_b[bb.mem_addr[9:2]] <= bb.mem_wdata;
      pipe_b[0] <= bb.mem_en ? ram_b[bb.mem_addr[9:2]] : 32'hBAAD_F00D;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign ba.mem_rdata = pipe_a;
   assign bb.mem_rdata = pipe_b[2];

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_ack;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      @(negedge clk);
      pre_idx  = 8'(idx);
      pre_data = d;
      pre_en   = 1'b1;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   task automatic chk_a_zero(input string tag);
      chk({tag, ".if_ack"},    32'(ba.if_ack), 0);
      chk({tag, ".d_ack"},     32'(ba.d_ack), 0);
      chk({tag, ".mem_en"},    32'(ba.mem_en), 0);
      chk({tag, ".mem_we"},    32'(ba.mem_we), 0);
      chk({tag, ".busy"},      32'(ba.busy), 0);
      chk({tag, ".grant_d"},   32'(ba.grant_d), 0);
      chk({tag, ".mem_addr"},  ba.mem_addr, 0);
      chk({tag, ".mem_wdata"}, ba.mem_wdata, 0);
      chk({tag, ".if_rdata"},  ba.if_rdata, 0);
      chk({tag, ".d_rdata"},   ba.d_rdata, 0);
   endtask

   // Single transaction on DUT A; cycle 0 is the cycle whose closing edge samples req.
   task automatic run_a(input int k, input vec_t v);
      int          ack_cyc = -1, en_cyc = -1, en_cnt = 0, other = 0;
      logic        we_s = 1'b0, g_s = 1'b0;
      logic [31:0] addr_s = '0, wd_s = '0, rd = '0;
      string       t;
      t = $sformatf("vec%0d", k);
      @(negedge clk);
      if (v.is_d) begin
         ba.d_req = 1'b1; ba.d_we = v.we; ba.d_addr = v.addr; ba.d_wdata = v.wdata;
      end else begin
         ba.if_req = 1'b1; ba.if_addr = v.addr;
      end
      for (int c = 1; c <= 30 && ack_cyc < 0; c++) begin
         @(negedge clk);
         if (ba.mem_en) begin
            en_cnt++; en_cyc = c; we_s = ba.mem_we; addr_s = ba.mem_addr;
            wd_s = ba.mem_wdata; g_s = ba.grant_d;
         end
         if (v.is_d ? ba.if_ack : ba.d_ack) other++;
         if (v.is_d ? ba.d_ack : ba.if_ack) begin
            ack_cyc = c;
            rd = v.is_d ? ba.d_rdata : ba.if_rdata;
            ba.d_req = 1'b0; ba.if_req = 1'b0;
         end
      end
      chk({t, ".ack_cycle"}, 32'(ack_cyc), 32'(v.exp_ack));
      chk({t, ".rdata"},     rd, v.exp_rdata);
      chk({t, ".en_cycle"},  32'(en_cyc), 1);
      chk({t, ".en_count"},  32'(en_cnt), 1);
      chk({t, ".mem_we"},    32'(we_s), 32'(v.we));
      chk({t, ".mem_addr"},  addr_s, v.addr);
      chk({t, ".grant_d"},   32'(g_s), 32'(v.is_d));
      chk({t, ".other_ack"}, 32'(other), 0);
      if (v.we) chk({t, ".mem_wdata"}, wd_s, v.wdata);
      @(negedge clk);
      chk({t, ".idle_busy"}, 32'(ba.busy), 0);
      chk({t, ".rdata_hold"}, v.is_d ? ba.d_rdata : ba.if_rdata, v.exp_rdata);
   endtask

   // Read on DUT B; reports ack cycle, data, issue cycle and a per-cycle busy mask.
   task automatic run_b_read(input bit is_d, input logic [31:0] addr, output int ack_cyc,
                             output logic [31:0] rd, output int en_cyc, output logic [7:0] busy_m);
      ack_cyc = -1; en_cyc = -1; rd = '0; busy_m = '0;
      @(negedge clk);
      if (is_d) begin bb.d_req = 1'b1; bb.d_we = 1'b0; bb.d_addr = addr; end
      else begin bb.if_req = 1'b1; bb.if_addr = addr; end
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         busy_m[c] = bb.busy;
         if (bb.mem_en) en_cyc = c;
         if ((is_d ? bb.d_ack : bb.if_ack) && ack_cyc < 0) begin
            ack_cyc = c;
            rd = is_d ? bb.d_rdata : bb.if_rdata;
            bb.d_req = 1'b0; bb.if_req = 1'b0;
         end
      end
      bb.d_req = 1'b0; bb.if_req = 1'b0;
   endtask

   vec_t vecs [7];

   initial begin
      int          d_acks[$], if_acks[$];
      int          both, n_if, ack_cyc, en_cyc, stray;
      logic [31:0] rd, d_rd, if_rd;
      logic [7:0]  busy_m;

      vecs[0] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         32'h0050_0093, 3};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         2};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 3};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 32'hDEAD_BEEF, 2};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'hCAFE_F00D, 3};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h0050_0093, 3};
      vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hA5A5_5A5A, 3};

      rst_a = 1'b1; rst_b = 1'b1;
      ba.if_req = 1'b0; ba.if_addr = '0; ba.d_req = 1'b0; ba.d_we = 1'b0;
      ba.d_addr = '0; ba.d_wdata = '0;
      bb.if_req = 1'b0; bb.if_addr = '0; bb.d_req = 1'b0; bb.d_we = 1'b0;
      bb.d_addr = '0; bb.d_wdata = '0;

      preload(2,   32'h0050_0093);
      preload(8,   32'h1234_5678);
      preload(255, 32'hA5A5_5A5A);
      @(negedge clk);
      chk_a_zero("reset");
      rst_a = 1'b0; rst_b = 1'b0;

      for (int k = 0; k < 7; k++) run_a(k, vecs[k]);

      // Reset held two cycles while a data read sits in WAIT.
      @(negedge clk);
      ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 32'h100;
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b1; ba.d_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_a = 1'b0;
      chk_a_zero("midrst");
      stray = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (ba.d_ack || ba.if_ack || ba.busy) stray++;
      end
      chk("midrst.no_activity", 32'(stray), 0);

      // Contention: data reads 0x100 once, fetch keeps req high across two transactions.
      @(negedge clk);
      ba.d_req = 1'b1; ba.d_we = 1'b0; ba.d_addr = 32'h100;
      ba.if_req = 1'b1; ba.if_addr = 32'h8;
      both = 0; n_if = 0; d_rd = '0; if_rd = '0;
      for (int c = 1; c <= 30 && (ba.d_req || ba.if_req); c++) begin
         @(negedge clk);
         if (ba.d_ack && ba.if_ack) both++;
         if (ba.d_ack) begin d_acks.push_back(c); d_rd = ba.d_rdata; ba.d_req = 1'b0; end
         if (ba.if_ack) begin
            if_acks.push_back(c); if_rd = ba.if_rdata; n_if++;
            if (n_if == 2) ba.if_req = 1'b0;
         end
      end
      ba.d_req = 1'b0; ba.if_req = 1'b0;
      chk("cont.both_ack", 32'(both), 0);
      chk("cont.d_count", 32'(d_acks.size()), 1);
      chk("cont.if_count", 32'(if_acks.size()), 2);
`ifdef RV32E_ARB_ROUND_ROBIN_EN
      if (d_acks.size() == 1)  chk("cont.d_ack0", 32'(d_acks[0]), 7);
      if (if_acks.size() == 2) begin
         chk("cont.if_ack0", 32'(if_acks[0]), 3);
         chk("cont.if_ack1", 32'(if_acks[1]), 11);
      end
`else
      if (d_acks.size() == 1)  chk("cont.d_ack0", 32'(d_acks[0]), 3);
      if (if_acks.size() == 2) begin
         chk("cont.if_ack0", 32'(if_acks[0]), 7);
         chk("cont.if_ack1", 32'(if_acks[1]), 11);
      end
`endif
      chk("cont.d_rdata", d_rd, 32'hDEAD_BEEF);
      chk("cont.if_rdata", if_rd, 32'h0050_0093);

      // MEM_LATENCY=3 data read.
      run_b_read(1'b1, 32'h20, ack_cyc, rd, en_cyc, busy_m);
      chk("lat3.en_cycle", 32'(en_cyc), 1);
      chk("lat3.ack_cycle", 32'(ack_cyc), 5);
      chk("lat3.rdata", rd, 32'h1234_5678);
      chk("lat3.busy_mask", 32'(busy_m), 32'h3E);

      // Reset during WAIT of a fetch read on DUT B: that request must never be acked.
      @(negedge clk);
      bb.if_req = 1'b1; bb.if_addr = 32'h8;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1; bb.if_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b0;
      chk("wrst.busy", 32'(bb.busy), 0);
      chk("wrst.if_rdata", bb.if_rdata, 0);
      stray = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (bb.if_ack || bb.d_ack) stray++;
      end
      chk("wrst.no_ack", 32'(stray), 0);
      run_b_read(1'b0, 32'h20, ack_cyc, rd, en_cyc, busy_m);
      chk("wrst.new_ack_cycle", 32'(ack_cyc), 5);
      chk("wrst.new_rdata", rd, 32'h1234_5678);
      chk("wrst.new_busy_mask", 32'(busy_m), 32'h3E);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
